// File: rtl/fpu_div_pkg.sv
// rtl/fpu_div_pkg.sv - shared FPU constants, FSM encodings and operand class type
package fpu_div_pkg;

    localparam int          BIAS      = 127;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam logic [22:0] QNAN_MANT = 23'd1;
    localparam int          DIV_ITERS = 26;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLASS = 2'd1;
    localparam logic [1:0] ST_DIV   = 2'd2;
    localparam logic [1:0] ST_PACK  = 2'd3;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp,
                                            input logic [22:0] mant);
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fp_special_decode.sv
// rtl/fp_special_decode.sv - classifies two single-precision operands as zero/inf/nan
module fp_special_decode
    import fpu_div_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output fp_class_t   cls_a,
    output fp_class_t   cls_b
);

    // Exponent 0 is treated as zero regardless of mantissa: denormals flush.
    always_comb begin
        cls_a.is_zero = (a[30:23] == 8'd0);
        cls_a.is_inf  = (a[30:23] == EXP_MAX) && (a[22:0] == 23'd0);
        cls_a.is_nan  = (a[30:23] == EXP_MAX) && (a[22:0] != 23'd0);
        cls_b.is_zero = (b[30:23] == 8'd0);
        cls_b.is_inf  = (b[30:23] == EXP_MAX) && (b[22:0] == 23'd0);
        cls_b.is_nan  = (b[30:23] == EXP_MAX) && (b[22:0] != 23'd0);
    end

endmodule

// File: rtl/fpu_div.sv
// rtl/fpu_div.sv - sequential IEEE-754 single divider, radix-2 restoring, start/busy/done
module fpu_div
    import fpu_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Res,
    output logic        busy,
    output logic        done
);

    logic [1:0]  state;
    logic [31:0] a_q, b_q;
    logic [24:0] rem;
    logic [25:0] quo;
    logic [4:0]  cnt;

    fp_class_t   cls_a, cls_b;
    logic        sign;
    logic        special;
    logic [31:0] special_res;
    logic [23:0] ma, mb;
    logic        rem_ge;
    logic [24:0] rem_keep;
    logic signed [9:0] e_base, e_fin;
    logic [23:0] m_rnd;
    logic [22:0] m_fin;
    logic [31:0] pack_res;

    fp_special_decode u_decode (
        .a     (a_q),
        .b     (b_q),
        .cls_a (cls_a),
        .cls_b (cls_b)
    );

    assign sign = a_q[31] ^ b_q[31];
    assign ma   = {1'b1, a_q[22:0]};
    assign mb   = {1'b1, b_q[22:0]};
    assign busy = (state != ST_IDLE);

    always_comb begin
        special     = 1'b1;
        special_res = fp_pack(sign, EXP_MAX, QNAN_MANT);
        if (cls_a.is_nan || cls_b.is_nan)
            special_res = fp_pack(sign, EXP_MAX, QNAN_MANT);
        else if (cls_a.is_zero && cls_b.is_zero)
            special_res = fp_pack(sign, EXP_MAX, QNAN_MANT);
        else if (cls_a.is_inf && cls_b.is_inf)
            special_res = fp_pack(sign, EXP_MAX, QNAN_MANT);
        else if (cls_b.is_zero || cls_a.is_inf)
            special_res = fp_pack(sign, EXP_MAX, 23'd0);
        else if (cls_a.is_zero || cls_b.is_inf)
            special_res = fp_pack(sign, 8'd0, 23'd0);
        else
            special = 1'b0;
    end

    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_keep = rem_ge ? (rem - {1'b0, mb}) : rem;

    // Q[25] set means the quotient is in [1,2); otherwise in [0.5,1) and one bit lower.
    always_comb begin
        e_base = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
               + $signed(10'(BIAS));
        if (quo[25]) begin
            m_rnd = {1'b0, quo[24:2]} + {23'd0, quo[1]};
        end else begin
            m_rnd  = {1'b0, quo[23:1]} + {23'd0, quo[0]};
            e_base = e_base - 10'sd1;
        end
        if (m_rnd[23]) begin
            m_fin = 23'd0;
            e_fin = e_base + 10'sd1;
        end else begin
            m_fin = m_rnd[22:0];
            e_fin = e_base;
        end
        if (e_fin >= 10'sd255)
            pack_res = fp_pack(sign, EXP_MAX, 23'd0);
        else if (e_fin <= 10'sd0)
            pack_res = fp_pack(sign, 8'd0, 23'd0);
        else
            pack_res = fp_pack(sign, e_fin[7:0], m_fin);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            rem   <= 25'd0;
            quo   <= 26'd0;
            cnt   <= 5'd0;
            Res   <= 32'd0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        state <= ST_CLASS;
                    end
                end
                ST_CLASS: begin
                    if (special) begin
                        Res   <= special_res;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        rem   <= {1'b0, ma};
                        quo   <= 26'd0;
                        cnt   <= 5'd0;
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    quo <= {quo[24:0], rem_ge};
                    rem <= {rem_keep[23:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITERS - 1))
                        state <= ST_PACK;
                end
                default: begin
                    Res   <= pack_res;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_div.sv
// tb/tb_fpu_div.sv - directed self-checking bench for fpu_div
`timescale 1ns/1ps
module tb_fpu_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic [31:0] Res;
    logic        busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .Res   (Res),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction: start sampled at edge 0, latency counted in edges after that.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat);
        int  n;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        busy_ok = busy;
        n       = 0;
        seen    = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
            else if (!busy) busy_ok = 0;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " res"}, Res, exp_res);
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_c, second_c;
        int n;
        bit extra;

        reset = 1'b0; start = 1'b0; A = 32'd0; B = 32'd0;
        #23;
        check("reset res",  Res, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_div("6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 28);
        run_div("1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);
        run_div("2/0",       32'h40000000, 32'h00000000, 32'h7F800000, 1);
        run_div("0/0",       32'h00000000, 32'h00000000, 32'h7F800001, 1);
        run_div("-inf/inf",  32'hFF800000, 32'h7F800000, 32'hFF800001, 1);
        run_div("0/-2",      32'h00000000, 32'hC0000000, 32'h80000000, 1);
        run_div("overflow",  32'h7F000000, 32'h00800000, 32'h7F800000, 28);
        run_div("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, 28);

        // start held high: back-to-back operations, second accepted in the done cycle
        done_cnt = 0; first_c = -1; second_c = -1;
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                if (first_c < 0) first_c = c;
                else if (second_c < 0) second_c = c;
            end
        end
        start = 1'b0;
        check("hold done count", 32'(done_cnt), 32'd2);
        check("hold first done", 32'(first_c), 32'd28);
        check("hold second done", 32'(second_c), 32'd57);
        check("hold res", Res, 32'h40400000);
        n = 0;
        while (busy && n < 60) begin @(posedge clk); #1; n++; end
        check("hold drain", {31'd0, busy}, 32'd0);

        // start pulse while busy must not re-capture operands
        @(negedge clk);
        A = 32'h40C00000; B = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 32'hFFFFFFFF; B = 32'hFFFFFFFF;
        n = 0;
        while (!done && n < 40) begin @(posedge clk); #1; n++; end
        check("ignore res", Res, 32'h40400000);
        extra = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done) extra = 1;
        end
        check("ignore no extra", {31'd0, extra}, 32'd0);

        // asynchronous abort mid-divide
        @(negedge clk);
        A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort res",  Res, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        extra = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done) extra = 1;
        end
        check("abort no done", {31'd0, extra}, 32'd0);
        run_div("after reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
